// File: rtl/wbu_if.sv
// Write-back stage bus: LSU packet handshake, commit handshake, GPR read ports and retire count.
// The slave modport is the write-back stage; master is the surrounding pipeline.
interface wbu_if #(
    parameter int unsigned CNT_W = 64
);
    logic             lsu_valid;
    logic [103:0]     lsu_data;
    logic             wbu_ready;
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic             commit_ready;
    logic [4:0]       rs1_addr;
    logic [31:0]      rs1_data;
    logic [4:0]       rs2_addr;
    logic [31:0]      rs2_data;
    logic [CNT_W-1:0] instret;

    modport slave (
        input  lsu_valid, lsu_data, commit_ready, rs1_addr, rs2_addr,
        output wbu_ready, commit_valid, commit_pc, rs1_data, rs2_data, instret
    );

    modport master (
        output lsu_valid, lsu_data, commit_ready, rs1_addr, rs2_addr,
        input  wbu_ready, commit_valid, commit_pc, rs1_data, rs2_data, instret
    );
endinterface

// File: rtl/wbu.sv
// Write-back stage: one-entry pipeline register, GPR file write/read, commit and retire counter.
// Define WBU_BYPASS_EN to forward the value being written this cycle onto matching read ports.
module wbu #(
    parameter int unsigned NR_GPR = 32,
    parameter int unsigned CNT_W  = 64
) (
    input logic  clk,
    input logic  rst,
    wbu_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NR_GPR);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             wb_valid;
    logic [103:0]     wb_data;
    logic [31:0]      gpr [NR_GPR];
    logic [CNT_W-1:0] instret_q;

    logic            ready;
    logic            accept;
    logic            commit;
    logic            gpr_we;
    logic [31:0]     alu_res;
    logic [31:0]     load_data;
    logic [31:0]     pc;
    logic [31:0]     wb_value;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [1:0]      wb_sel;
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rs1_idx;
    logic [IdxW-1:0] rs2_idx;

    assign ready  = ~wb_valid | bus.commit_ready;
    assign accept = bus.lsu_valid & ready;
    assign commit = wb_valid & bus.commit_ready;

    assign {alu_res, load_data, rd, rd_wen, wb_sel, pc} = wb_data;

    assign gpr_we  = commit & rd_wen & (rd != 5'd0);
    assign wr_idx  = rd[IdxW-1:0];
    assign rs1_idx = bus.rs1_addr[IdxW-1:0];
    assign rs2_idx = bus.rs2_addr[IdxW-1:0];

    always_comb begin
        wb_value = alu_res;
        case (wb_sel)
            2'b01:   wb_value = load_data;
            2'b10:   wb_value = pc + 32'd4;
            default: wb_value = alu_res;
        endcase
    end

    // A new packet may load on the same edge the held one commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
        end else if (accept) begin
            wb_valid <= 1'b1;
            wb_data  <= bus.lsu_data;
        end else if (commit) begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_GPR; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_we) begin
            gpr[wr_idx] <= wb_value;
        end
    end

    always_comb begin
        bus.rs1_data = (rs1_idx == '0) ? 32'd0 : gpr[rs1_idx];
        bus.rs2_data = (rs2_idx == '0) ? 32'd0 : gpr[rs2_idx];
`ifdef WBU_BYPASS_EN
        if (gpr_we && (bus.rs1_addr == rd)) begin
            bus.rs1_data = wb_value;
        end
        if (gpr_we && (bus.rs2_addr == rd)) begin
            bus.rs2_data = wb_value;
        end
`endif
    end

    assign bus.wbu_ready    = ready;
    assign bus.commit_valid = wb_valid;
    assign bus.commit_pc    = pc;
    assign bus.instret      = instret_q;
endmodule
